// File: rtl/peripheral_rxfifo.sv
// Purpose : J1 I/O-mapped byte FIFO buffering serial-receiver bytes for firmware.
// Latency : push/pop take effect on the strobe edge; d_out is combinational.
// Backpressure: none upstream; bytes arriving while full are dropped and flagged.
//
// Ports:
//   clk, rst        system clock, asynchronous active-low reset
//   d_in, cs, addr,
//   rd, wr          J1 I/O bus access (write data, select, address, strobes)
//   d_out           read data, 16'h0000 unless cs && rd
//   rx_data,
//   rx_valid        byte from the serial receiver, one-cycle strobe
//   not_empty       registered "FIFO holds data" indication
//
// Register map: 0x0 DATA (pop on read), 0x2 STATUS, 0x4 THRESH, 0x6 CTRL (wr only).
module peripheral_rxfifo #(
    parameter int          AW      = 4,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] d_out,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        not_empty
);

    localparam int         DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    localparam logic [3:0] A_DATA   = 4'h0;
    localparam logic [3:0] A_STATUS = 4'h2;
    localparam logic [3:0] A_THRESH = 4'h4;
    localparam logic [3:0] A_CTRL   = 4'h6;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic [AW:0]   threshold;
    logic          overflow;
    logic          timeout_flag;
    logic          rd_q;
    logic [15:0]   idle_cnt;

    logic full;
    logic empty;
    logic thr_hit;
    logic data_acc;
    logic pop;
    logic push_ok;
    logic drop;
    logic flush;
    logic clr_ovf;
    logic clr_to;
    logic thr_wr;
    logic idle_inc;
    logic to_set;

    logic [AW:0]   thr_wr_val;
    logic [AW+5:0] status_bits;

    // Upper write-data bits have no destination.
    logic unused_d_in;
    assign unused_d_in = &{1'b0, d_in};

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign thr_hit = (count >= threshold);

    // A read of DATA pops once, on the first edge of the access; rd_q blocks
    // further pops while the strobe is held.
    assign data_acc = cs && rd && (addr == A_DATA);
    assign pop      = data_acc && !rd_q && !empty;

    // A pop in the same cycle frees a slot, so a push onto a full FIFO is
    // accepted when it coincides with a pop.
    assign push_ok = rx_valid && (!full || pop);
    assign drop    = rx_valid && full && !pop;

    assign flush   = cs && wr && (addr == A_CTRL) && d_in[0];
    assign clr_ovf = cs && wr && (addr == A_CTRL) && d_in[1];
    assign clr_to  = cs && wr && (addr == A_CTRL) && d_in[2];
    assign thr_wr  = cs && wr && (addr == A_THRESH);

    // A threshold of zero would make thr_hit permanently true; store 1 instead.
    assign thr_wr_val = (d_in[AW:0] == '0) ? (AW+1)'(1) : d_in[AW:0];

    // Idle counter only runs while data is waiting and no timeout is pending;
    // it saturates at TIMEOUT so a cleared flag does not re-fire until a new
    // byte restarts the count.
    assign idle_inc = (count != '0) && !timeout_flag && (idle_cnt != TIMEOUT)
                      && !rx_valid && !flush;
    assign to_set   = idle_inc && ((idle_cnt + 16'd1) == TIMEOUT);

    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else begin
            case ({push_ok, pop})
                2'b10:   count_nxt = count + (AW+1)'(1);
                2'b01:   count_nxt = count - (AW+1)'(1);
                default: count_nxt = count;
            endcase
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            not_empty <= 1'b0;
            rd_q      <= 1'b0;
        end else begin
            rd_q      <= data_acc;
            count     <= count_nxt;
            not_empty <= (count_nxt != '0);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + AW'(1);
                if (pop)     rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Sticky flags: a new event in the same cycle as its clear wins, so the
    // event is never silently lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow     <= 1'b0;
            timeout_flag <= 1'b0;
            idle_cnt     <= '0;
            threshold    <= (AW+1)'(1);
        end else begin
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;

            if (to_set)       timeout_flag <= 1'b1;
            else if (clr_to)  timeout_flag <= 1'b0;

            if (rx_valid || flush || (count == '0)) idle_cnt <= '0;
            else if (idle_inc)                       idle_cnt <= idle_cnt + 16'd1;

            if (thr_wr) threshold <= thr_wr_val;
        end
    end

    assign status_bits = {timeout_flag, thr_hit, overflow, full, empty, count};

    always_comb begin
        d_out = 16'h0000;
        if (cs && rd) begin
            case (addr)
                A_DATA:   d_out = empty ? 16'h0000 : {8'h00, mem[rd_ptr]};
                A_STATUS: d_out = 16'(status_bits);
                A_THRESH: d_out = 16'(threshold);
                default:  d_out = 16'h0000;
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_rxfifo.sv
module tb_peripheral_rxfifo;

    logic        clk;
    logic        rst;
    logic [15:0] d_in;
    logic        cs;
    logic [3:0]  addr;
    logic        rd;
    logic        wr;
    logic [15:0] d_out;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        not_empty;

    logic        chk_en;
    logic [16:0] exp_q [$];
    string       name_q [$];
    int          compared;
    int          mismatched;

    peripheral_rxfifo #(.AW(4), .TIMEOUT(16'd10)) dut (
        .clk      (clk),
        .rst      (rst),
        .d_in     (d_in),
        .cs       (cs),
        .addr     (addr),
        .rd       (rd),
        .wr       (wr),
        .d_out    (d_out),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .not_empty(not_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: whenever the driver flags an observation cycle, pop the
    // expectation and compare (bit16 selects not_empty instead of d_out).
    always @(negedge clk) begin
        if (chk_en) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_sample: no expectation queued, d_out=%h", d_out);
            end else begin
                logic [16:0] e;
                string       nm;
                logic [15:0] act;
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                act = e[16] ? {15'b0, not_empty} : d_out;
                if (act !== e[15:0]) begin
                    mismatched++;
                    $display("FAIL %s: got %h expected %h", nm, act, e[15:0]);
                end
            end
        end
    end

    // Bus read, optionally with a receiver byte in the access cycle.
    // DATA reads are followed by one idle cycle so rd_q drops between pops.
    task automatic rd_acc(input logic [3:0] a, input logic [15:0] e, input string nm,
                          input int hold, input bit do_push, input logic [7:0] b);
        cs = 1'b1; rd = 1'b1; addr = a;
        if (do_push) begin rx_valid = 1'b1; rx_data = b; end
        exp_q.push_back({1'b0, e});
        name_q.push_back(nm);
        chk_en = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b0; rx_valid = 1'b0;
        repeat (hold - 1) begin @(posedge clk); #1; end
        cs = 1'b0; rd = 1'b0;
        if (a == 4'h0) begin @(posedge clk); #1; end
    endtask

    task automatic rd_reg(input logic [3:0] a, input logic [15:0] e, input string nm);
        rd_acc(a, e, nm, 1, 1'b0, 8'h00);
    endtask

    task automatic wr_acc(input logic [3:0] a, input logic [15:0] d,
                          input bit do_push, input logic [7:0] b);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
        if (do_push) begin rx_valid = 1'b1; rx_data = b; end
        @(posedge clk); #1;
        cs = 1'b0; wr = 1'b0; rx_valid = 1'b0;
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [15:0] d);
        wr_acc(a, d, 1'b0, 8'h00);
    endtask

    task automatic push(input logic [7:0] b);
        rx_valid = 1'b1; rx_data = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic check_ne(input logic e, input string nm);
        exp_q.push_back({1'b1, 15'b0, e});
        name_q.push_back(nm);
        chk_en = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b0;
    endtask

    task automatic idle_cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", compared);
        $fatal(1, "watchdog");
    end

    initial begin
        compared = 0; mismatched = 0;
        rst = 1'b0; d_in = '0; cs = 1'b0; addr = '0; rd = 1'b0; wr = 1'b0;
        rx_data = '0; rx_valid = 1'b0; chk_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Reset state
        rd_reg(4'h2, 16'h0020, "rst_status");
        rd_reg(4'h4, 16'h0001, "rst_thresh");
        check_ne(1'b0, "rst_not_empty");

        // Async reset mid-operation with count=5
        wr_reg(4'h4, 16'h0003);
        for (int i = 1; i <= 5; i++) push(8'(i));
        rd_reg(4'h2, 16'h0105, "pre_rst_status");
        check_ne(1'b1, "pre_rst_not_empty");
        rst = 1'b0;
        rd_reg(4'h2, 16'h0020, "async_rst_status");
        rd_reg(4'h4, 16'h0001, "async_rst_thresh");
        check_ne(1'b0, "async_rst_not_empty");
        rst = 1'b1;

        // Ordered push/pop
        push(8'h41); push(8'h54); push(8'h0D);
        rd_reg(4'h2, 16'h0103, "ord_status3");
        rd_reg(4'h0, 16'h0041, "ord_data0");
        rd_reg(4'h0, 16'h0054, "ord_data1");
        rd_reg(4'h0, 16'h000D, "ord_data2");
        rd_reg(4'h0, 16'h0000, "ord_data_empty");
        rd_reg(4'h2, 16'h0020, "ord_status_empty");

        // Held read pops once
        push(8'hAA); push(8'hBB);
        rd_acc(4'h0, 16'h00AA, "held_data", 3, 1'b0, 8'h00);
        rd_reg(4'h2, 16'h0101, "held_status");
        rd_reg(4'h0, 16'h00BB, "held_data2");

        // Overflow
        for (int i = 0; i <= 16; i++) push(8'(i));
        rd_reg(4'h2, 16'h01D0, "ovf_status");
        wr_reg(4'h6, 16'h0002);
        rd_reg(4'h2, 16'h0150, "ovf_cleared");
        for (int i = 0; i < 16; i++) rd_reg(4'h0, 16'(i), "ovf_data");
        rd_reg(4'h2, 16'h0220, "ovf_drain_timeout");
        wr_reg(4'h6, 16'h0004);
        rd_reg(4'h2, 16'h0020, "to_cleared");

        // Simultaneous push+pop while full
        for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
        rd_reg(4'h2, 16'h0150, "sim_full_status");
        rd_acc(4'h0, 16'h0080, "sim_full_data", 1, 1'b1, 8'h99);
        rd_reg(4'h2, 16'h0150, "sim_full_after");
        for (int i = 1; i < 16; i++) rd_reg(4'h0, 16'h0080 + 16'(i), "sim_full_drain");
        rd_reg(4'h0, 16'h0099, "sim_full_last");
        rd_reg(4'h2, 16'h0220, "sim_full_end");
        wr_reg(4'h6, 16'h0004);

        // Simultaneous push+pop while empty
        rd_acc(4'h0, 16'h0000, "sim_empty_data", 1, 1'b1, 8'h77);
        rd_reg(4'h2, 16'h0101, "sim_empty_status");
        rd_reg(4'h0, 16'h0077, "sim_empty_pop");
        rd_reg(4'h2, 16'h0020, "sim_empty_end");

        // Threshold and timeout
        wr_reg(4'h4, 16'h0004);
        rd_reg(4'h4, 16'h0004, "thr_read");
        push(8'h01); push(8'h02); push(8'h03);
        rd_reg(4'h2, 16'h0003, "thr_cnt3");
        push(8'h04);
        rd_reg(4'h2, 16'h0104, "thr_cnt4");
        idle_cyc(8);
        rd_reg(4'h2, 16'h0104, "to_edge9");
        rd_reg(4'h2, 16'h0304, "to_edge10");
        wr_reg(4'h6, 16'h0005);
        rd_reg(4'h2, 16'h0020, "flush_clear");
        check_ne(1'b0, "flush_not_empty");

        // Flush beats a same-cycle push
        push(8'h55);
        wr_acc(4'h6, 16'h0001, 1'b1, 8'h66);
        rd_reg(4'h2, 16'h0020, "flush_push_status");
        rd_reg(4'h0, 16'h0000, "flush_push_data");

        // Threshold encoding and unmapped address
        wr_reg(4'h4, 16'h0000);
        rd_reg(4'h4, 16'h0001, "thr_zero");
        wr_reg(4'h4, 16'h0014);
        rd_reg(4'h4, 16'h0014, "thr_20");
        rd_reg(4'h8, 16'h0000, "unmapped");

        idle_cyc(2);
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL leftover: got %0d unchecked expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
